// File: rtl/divider_pkg.sv
// divider_pkg
// Shared definitions for the iterative restoring divider:
//   - div_state_t : FSM state encoding (IDLE, LOAD, RUN, DONE)
//   - cnt_width() : width of the iteration counter for a given dividend width
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // The counter only has to hold WIDTH-1 down to 0, so clog2(WIDTH) bits
    // suffice. Clamped to 1 so a degenerate width still yields a legal vector.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division step.
// Ports:
//   rem_i     : partial remainder entering this step (DIV_WIDTH+1 bits)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor
//   rem_o     : partial remainder after this step
//   qbit_o    : quotient bit produced by this step
module div_step #(
    parameter int DIV_WIDTH = 4
) (
    input  logic [DIV_WIDTH:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH:0]   rem_o,
    output logic                 qbit_o
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH+1:0] trial;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and the shifted value fits in DIV_WIDTH+1 bits.
    assign shifted = {rem_i[DIV_WIDTH-1:0], bit_i};

    // One extra bit on the subtraction exposes the borrow.
    assign trial = {1'b0, shifted} - {2'b00, divisor_i};

    assign qbit_o = ~trial[DIV_WIDTH+1];
    assign rem_o  = qbit_o ? trial[DIV_WIDTH:0] : shifted;

endmodule

// File: rtl/iterative_divider.sv
// iterative_divider
// Sequential restoring divider: WIDTH-bit unsigned dividend by DIV_WIDTH-bit
// unsigned divisor, one quotient bit per clock, start/done handshake.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-high; dominates start
//   start       : request, accepted only in IDLE or DONE
//   dividend    : dividend, latched on an accepted start
//   divisor     : divisor, latched on an accepted start
//   busy        : high in LOAD and RUN
//   done        : one-cycle pulse in DONE
//   quotient    : result quotient, updated only when entering DONE
//   remainder   : result remainder, updated only when entering DONE
//   div_by_zero : set with done when the latched divisor was 0
module iterative_divider
    import divider_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    div_state_t           state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [WIDTH-1:0]     quot_q;
    logic [DIV_WIDTH-1:0] rem_out_q;

    logic [WIDTH-1:0]     dividend_q;
    logic [DIV_WIDTH-1:0] divisor_q;
    logic [DIV_WIDTH:0]   rem_q;
    logic [WIDTH-1:0]     q_q;
    logic [CW-1:0]        cnt_q;

    logic [DIV_WIDTH:0]   rem_d;
    logic                 qbit;
    logic [WIDTH-1:0]     q_d;
    logic                 accept;

    assign accept = ~reset & start & ((state_q == IDLE) | (state_q == DONE));

    div_step #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (q_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign q_d = {q_q[WIDTH-2:0], qbit};

    // Control FSM with registered outputs. The result registers are written
    // only on entry to DONE, so they hold steady in IDLE, LOAD and RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (divisor_q == '0) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        dbz_q     <= 1'b1;
                        quot_q    <= '1;
                        rem_out_q <= dividend_q[DIV_WIDTH-1:0];
                    end else begin
                        state_q <= RUN;
                        dbz_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        quot_q    <= q_d;
                        rem_out_q <= rem_d[DIV_WIDTH-1:0];
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reinitialised in
    // LOAD before being consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
        end
        if (state_q == LOAD) begin
            rem_q <= '0;
            q_q   <= dividend_q;
            cnt_q <= CNT_LAST;
        end else if (state_q == RUN) begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_out_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=8, DIV_WIDTH=4).
module tb_iterative_divider;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     dividend = '0;
    logic [DIV_WIDTH-1:0] divisor = '0;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    iterative_divider #(
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;   // index of the current cycle; cycle k ends at edge k

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction-level reference: each accepted start yields a result
    // computed with / and %, due a fixed number of cycles later.
    bit m_ok = 0;
    bit m_active = 0;
    int m_done_at, m_q, m_r, m_a, m_b;
    bit m_dz;
    bit e_busy = 0, e_done = 0, e_dz = 0;
    int e_q = 0, e_r = 0, e_a = 0, e_b = 1;

    initial begin
        bit accept;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_ok = 1; m_active = 0;
                e_busy = 0; e_done = 0; e_dz = 0; e_q = 0; e_r = 0;
            end else begin
                accept = start && !e_busy;
                if (accept) begin
                    m_active = 1;
                    m_a = int'(dividend);
                    m_b = int'(divisor);
                    if (divisor == 0) begin
                        m_done_at = cyc + 2;
                        m_q = (1 << WIDTH) - 1;
                        m_r = m_a % (1 << DIV_WIDTH);
                        m_dz = 1;
                    end else begin
                        m_done_at = cyc + WIDTH + 2;
                        m_q = m_a / m_b;
                        m_r = m_a % m_b;
                        m_dz = 0;
                    end
                end
                e_done = m_active && (cyc + 1 == m_done_at);
                e_busy = m_active && (cyc + 1 <  m_done_at);
                if (e_done) begin
                    m_active = 0;
                    e_q = m_q; e_r = m_r; e_dz = m_dz; e_a = m_a; e_b = m_b;
                end
            end
            cyc++;
        end
    end

    // Compare process: handshake every cycle, results whenever not busy.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                if (!e_busy) begin
                    chk("quotient", quotient, e_q);
                    chk("remainder", remainder, e_r);
                    chk("div_by_zero", div_by_zero, e_dz);
                end
                if (done && !div_by_zero && e_done && e_b != 0) begin
                    chk("inv_q_times_d_plus_r", int'(quotient) * e_b + int'(remainder), e_a);
                    chk("inv_r_lt_d", int'(remainder) < e_b, 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, output int at);
        int n = 0;
        at = -1;
        while (n < 40) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct { int a; int b; int q; int r; } vec_t;
    vec_t vecs[4] = '{
        '{0,   1,  0,  0},
        '{255, 15, 17, 0},
        '{15,  15, 1,  0},
        '{14,  15, 0,  14}
    };

    initial begin
        int s, at, at2, nd;
        int a, b;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_quotient", quotient, 0);
        chk("idle_remainder", remainder, 0);
        chk("idle_dbz", div_by_zero, 0);

        // 200 / 3; inputs scrambled after the start edge
        start = 1; dividend = 200; divisor = 3; s = cyc;
        step();
        start = 0; dividend = 0; divisor = 0;
        wait_done("d200", at);
        chk("d200_latency", at - s, 10);
        chk("d200_q", quotient, 66);
        chk("d200_r", remainder, 2);
        chk("d200_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("d200_pulse", done, 0);
        step();

        // back-to-back: 5/9 then 255/1 with start held into DONE
        start = 1; dividend = 5; divisor = 9; s = cyc;
        step();
        dividend = 255; divisor = 1;
        wait_done("b2b1", at);
        chk("b2b1_latency", at - s, 10);
        chk("b2b1_q", quotient, 0);
        chk("b2b1_r", remainder, 5);
        step();
        start = 0;
        wait_done("b2b2", at2);
        chk("b2b2_spacing", at2 - at, 10);
        chk("b2b2_q", quotient, 255);
        chk("b2b2_r", remainder, 0);
        step();

        // divide by zero
        start = 1; dividend = 7; divisor = 0; s = cyc;
        step();
        start = 0;
        wait_done("dz", at);
        chk("dz_latency", at - s, 2);
        chk("dz_q", quotient, 255);
        chk("dz_r", remainder, 7);
        chk("dz_flag", div_by_zero, 1);
        step(); step();
        chk("dz_held", div_by_zero, 1);

        // reset aborts a running operation; mid-run start is ignored
        start = 1; dividend = 100; divisor = 7; s = cyc;
        step();
        start = 0;
        while (cyc < s + 3) step();
        start = 1; dividend = 50; divisor = 5;
        step();
        start = 0;
        while (cyc < s + 5) step();
        reset = 1;
        step();
        reset = 0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);

        // boundary vectors
        foreach (vecs[i]) begin
            step();
            start = 1; dividend = WIDTH'(vecs[i].a); divisor = DIV_WIDTH'(vecs[i].b);
            step();
            start = 0;
            wait_done("vec", at);
            chk("vec_q", quotient, vecs[i].q);
            chk("vec_r", remainder, vecs[i].r);
        end

        // random sweep, nonzero divisors
        for (int k = 0; k < 1000; k++) begin
            step();
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 15));
            start = 1; dividend = WIDTH'(a); divisor = DIV_WIDTH'(b);
            step();
            start = 0;
            wait_done("sweep", at);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Sequential restoring divider: unsigned WIDTH-bit dividend by DIV_WIDTH-bit divisor, producing quotient and remainder one bit per clock. It is the inverse of the display path's small-constant multiplier. The display and coordinate logic use it to turn scaled pixel and sample values back into cell indices and offsets, where a single-cycle combinational divide would not meet timing. It uses a start/done handshake and holds its result until the next accepted start.

## Interface
- WIDTH, 8: dividend and quotient width; must be ≥ 2.
- DIV_WIDTH, 4: divisor and remainder width; must be ≤ WIDTH.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  captured on an accepted start.
- divisor  input  DIV_WIDTH  captured on an accepted start.
- busy  output  1  high while in LOAD or RUN.
- done  output  1  high for exactly one cycle, in state DONE.
- quotient  output  WIDTH  result; holds its value outside of RUN.
- remainder  output  DIV_WIDTH  result; holds its value outside of RUN.
- div_by_zero  output  1  high with done when the captured divisor was 0; held until the next accepted start.

## Operation
- States: IDLE, LOAD, RUN, DONE.
  - IDLE → LOAD on start.
  - LOAD → RUN, or LOAD → DONE if the captured divisor is 0.
  - RUN → DONE after WIDTH iterations.
  - DONE → LOAD on start, else DONE → IDLE.
- Accepted start: dividend and divisor are latched into internal registers. Input changes after that edge have no effect.
- LOAD:
  - Partial remainder register (DIV_WIDTH+1 bits) cleared.
  - Quotient shift register set to the dividend.
  - Iteration counter set to WIDTH-1.
  - div_by_zero cleared.
- RUN, each cycle:
  - trial = {rem[DIV_WIDTH-1:0], q[WIDTH-1]} − {1'b0, divisor}.
  - If the trial does not borrow: rem = trial, shift 1 into the quotient LSB. Otherwise shift the old value left with MSB in, and shift 0 into the quotient.
  - Counter decrements; leave RUN when the counter is 0.
- DONE: quotient and remainder are visible and done=1.
- Divide by zero: quotient = all ones, remainder = dividend[DIV_WIDTH-1:0], div_by_zero=1.
- Result invariants for a nonzero divisor:
  - quotient·divisor + remainder == dividend.
  - remainder < divisor.
  - remainder always fits in DIV_WIDTH bits.
- start while busy is ignored and not queued.
- start in DONE is accepted, so back-to-back operations lose no cycle beyond the LOAD cycle.

## Timing
- Reset, synchronous and dominating start:
  - State → IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
- Reset mid-operation aborts the operation with no done pulse.
- Latency, normal case: start sampled at edge N → LOAD in cycle N+1, RUN for cycles N+2 … N+WIDTH+1, done=1 in cycle N+WIDTH+2.
- Latency, divide by zero: done=1 in cycle N+2.
- busy is high from cycle N+1 until done rises; busy and done are never high together.
- quotient and remainder may change during RUN. Consumers sample them only when done=1 or later in IDLE.
- Throughput: one result per WIDTH+2 cycles under continuous start.

## Structure
- Package divider_pkg holds the state encoding typedef (div_state_t: IDLE, LOAD, RUN, DONE) and the counter-width function (clog2 of WIDTH).
- Sub-module div_step: combinational, one restoring step.
  - In: rem, next dividend bit, divisor.
  - Out: new rem, quotient bit.
- iterative_divider contains only the FSM, the registers and one div_step instance.

## Test plan
All scenarios use WIDTH=8 and DIV_WIDTH=4.
- reset, then idle 5 cycles → busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- start 200/3 → done exactly 10 cycles after the start edge, quotient=66, remainder=2, div_by_zero=0; one-cycle done pulse.
- start 5/9 then 255/1 back-to-back (start held into DONE) → quotient=0 r=5, then quotient=255 r=0; second done 10 cycles after the first.
- start 7/0 → done 2 cycles after start, quotient=255, remainder=7, div_by_zero=1.
- start 100/7, pulse start with 50/5 three cycles later, assert reset two cycles after that → second start ignored, no done, all outputs at reset values.
- Random sweep of 1000 dividend/divisor pairs (divisor ≠ 0) → quotient·divisor+remainder == dividend and remainder < divisor on every done.
